ntt_ctrl: RTL
=============

Name: ntt_ctrl

Overview:
- Sequencer for the Kyber 256-point in-place NTT/INTT: walks all 7 layers and issues one butterfly (coefficient pair plus zeta index) per cycle to the fqmul-based butterfly datapath.
- Issues the matching write-back addresses after a fixed pipeline latency.
- Inserts a drain gap between layers so read-after-write hazards on the coefficient RAM cannot occur.
- Sits between the top-level poly-op FSM (start/done) and the dual-port coefficient RAM, zeta ROM and butterfly unit.

Parameters:
- PIPE_LAT, 4, cycles from issue (bf_valid) to write-back (wr_en): RAM read plus butterfly; legal range 1..15.
- ADDR_W, 8, coefficient address width (log2 256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- inv  in  1  0 = forward NTT, 1 = inverse NTT; captured with start.
- issue_ready  in  1  datapath/RAM can accept an issue this cycle.
- busy  out  1  high from the cycle after accepted start until the done cycle (inclusive).
- done  out  1  one-cycle pulse after the final write-back.
- bf_valid  out  1  butterfly issued this cycle.
- rd_addr_a  out  ADDR_W  first coefficient index j.
- rd_addr_b  out  ADDR_W  j + len.
- zeta_idx  out  7  zeta ROM index k.
- wr_en  out  1  write-back strobe for both addresses.
- wr_addr_a  out  ADDR_W  delayed rd_addr_a.
- wr_addr_b  out  ADDR_W  delayed rd_addr_b.

Behaviour:
- Reset: state IDLE; all outputs 0; layer/butterfly counters, drain counter and write-back delay line cleared. Asserting reset mid-operation aborts immediately; no done pulse.
- Butterfly count within a layer: b = 0..127 (7-bit counter). Layer index: l = 0..6.
- Forward mode:
  - len = 128 >> l, s = log2 len.
  - addr_a = {b[6:s], 0, b[s-1:0]} (zero inserted at bit s).
  - addr_b = addr_a + len.
  - g = b >> s; k = 2^l + g.
- Inverse mode:
  - len = 2 << l, s = log2 len; addr_a and addr_b formed as in forward mode.
  - g = b >> s; k = (128 >> l) - 1 - g.
  - Final 1441 scaling is not part of this block.
- Address/zeta arithmetic is unsigned, exact, and never wraps by construction.
- FSM states:
  - IDLE: start=1 → ISSUE, l=0, b=0, inv latched. start while not IDLE is ignored.
  - ISSUE:
    - bf_valid = issue_ready; b advances only when issue_ready=1.
    - issue_ready=0 holds all issue outputs stable, with bf_valid=0.
    - After issuing b=127 → DRAIN, drain counter loaded with PIPE_LAT.
  - DRAIN:
    - No issues; counter decrements each cycle.
    - At 0: if l<6 → ISSUE with l+1, b=0; else → DONE.
    - Net effect: the first issue of the next layer comes no earlier than PIPE_LAT+1 cycles after the last issue of the previous layer.
  - DONE: done=1 for one cycle, busy=1 in the same cycle → IDLE. A start in this cycle is ignored.
- Write-back delay line:
  - PIPE_LAT-deep shift register of {valid, addr_a, addr_b}.
  - Shifts every cycle regardless of issue_ready, because datapath latency is fixed.
  - wr_en/wr_addr_* equal the bf_valid/rd_addr_* values from exactly PIPE_LAT cycles earlier.
- Timing with issue_ready held 1, start accepted at edge 0:
  - Layer l issues occupy cycles 1+l*(128+PIPE_LAT) through +127.
  - With PIPE_LAT=4: last issue at cycle 920, last wr_en at 924, done at 925.
- Outputs are registered; no combinational path from issue_ready to the address outputs (only to b advance and bf_valid).

Decomposition:
- kyber_pkg: KYBER_N=256, KYBER_Q=3329, KYBER_QINV=62209, NTT_LAYERS=7, LOG2N=8, typedef coeff_addr_t (8-bit), zeta_idx_t (7-bit), ntt_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module ntt_addr_gen: purely combinational {l, b, inv} → {addr_a, addr_b, zeta_idx}, unit-testable exhaustively (2×7×128 points).
- Delay line stays inline.

Test Plan:
- Forward, issue_ready=1, PIPE_LAT=4 → first issue cycle 1: addr 0/128, k=1; issue 128 (layer 1 start, cycle 133): addr 0/64, k=2; final issue cycle 920: addr 253/255, k=127; done cycle 925; exactly 896 wr_en.
- Inverse, issue_ready=1 → layer 0 b=0: addr 0/2, k=127; b=1: 1/3, k=127; b=2: 4/6, k=126; layer 6 b=127: addr 127/255, k=1.
- Hazard check → every layer's first bf_valid occurs ≥ 1 cycle after the previous layer's last wr_en; scoreboard confirms each address is written exactly once per layer.
- Random issue_ready=0 bubbles (~30%) → issued sequence identical to the no-stall case; each wr_en follows its bf_valid by exactly PIPE_LAT cycles; done still pulses once.
- rst asserted mid-layer 3 → all outputs 0 asynchronously, no done pulse; a new start then yields the full clean sequence.
- start pulsed while busy and in the DONE cycle → ignored; inv toggled mid-run → no effect on the ongoing run.

Source files
------------

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, address/zeta types and NTT sequencer states
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = 62209;
  localparam int NTT_LAYERS = 7;
  localparam int LOG2N      = 8;

  typedef logic [LOG2N-1:0] coeff_addr_t;
  typedef logic [6:0]       zeta_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ntt_state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - combinational butterfly address and zeta index generator
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic [2:0] layer,
  input  logic [6:0] bfly,
  input  logic       inv,
  output coeff_addr_t addr_a,
  output coeff_addr_t addr_b,
  output zeta_idx_t   zeta_idx
);

  logic [2:0] shamt;
  logic [7:0] len;
  logic [7:0] grp;
  logic [7:0] low;

  // Split b into group and offset around bit s, then insert a zero at bit s.
  // Forward walks len 128 down to 2, inverse walks len 2 up to 128.
  always_comb begin
    shamt    = inv ? (layer + 3'd1) : (3'd7 - layer);
    len      = 8'd1 << shamt;
    grp      = {1'b0, bfly} >> shamt;
    low      = {1'b0, bfly} & (len - 8'd1);
    addr_a   = ((grp << shamt) << 1) | low;
    addr_b   = addr_a + len;
    // (128 >> l) - 1 equals 7'h7f >> l, which keeps the inverse index in 7 bits.
    zeta_idx = inv ? ((7'h7f >> layer) - grp[6:0])
                   : ((7'd1 << layer) + grp[6:0]);
  end

endmodule

// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - Kyber NTT/INTT layer sequencer with write-back delay line
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inv,
  input  logic              issue_ready,
  output logic              busy,
  output logic              done,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [6:0]        zeta_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int PW = 2 * ADDR_W + 1;

  ntt_state_t  state, state_nxt;
  logic [2:0]  layer, layer_nxt;
  logic [6:0]  bfly, bfly_nxt;
  logic        inv_q, inv_nxt;
  logic [3:0]  drain_cnt, drain_nxt;

  coeff_addr_t gen_a, gen_b;
  zeta_idx_t   gen_k;

  logic [PW-1:0] pipe [PIPE_LAT];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next counter values; drain leaves after PIPE_LAT idle cycles.
  always_comb begin
    state_nxt = state;
    layer_nxt = layer;
    bfly_nxt  = bfly;
    inv_nxt   = inv_q;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          layer_nxt = 3'd0;
          bfly_nxt  = 7'd0;
          inv_nxt   = inv;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          bfly_nxt = bfly + 7'd1;
          if (bfly == 7'd127) begin
            state_nxt = DRAIN;
            drain_nxt = 4'(PIPE_LAT);
          end
        end
      end
      DRAIN: begin
        drain_nxt = drain_cnt - 4'd1;
        if (drain_cnt <= 4'd1) begin
          drain_nxt = 4'd0;
          if (layer < 3'(NTT_LAYERS - 1)) begin
            state_nxt = ISSUE;
            layer_nxt = layer + 3'd1;
            bfly_nxt  = 7'd0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Layer, butterfly, mode and drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer     <= 3'd0;
      bfly      <= 7'd0;
      inv_q     <= 1'b0;
      drain_cnt <= 4'd0;
    end else begin
      layer     <= layer_nxt;
      bfly      <= bfly_nxt;
      inv_q     <= inv_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Status and issue strobe decode; only bf_valid sees issue_ready directly.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    bf_valid = (state == ISSUE) && issue_ready;
  end

  // Addresses are precomputed from next-state counters so the outputs are registered.
  ntt_addr_gen u_addr_gen (
    .layer    (layer_nxt),
    .bfly     (bfly_nxt),
    .inv      (inv_nxt),
    .addr_a   (gen_a),
    .addr_b   (gen_b),
    .zeta_idx (gen_k)
  );

  // Issue address registers; zero outside ISSUE, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
    end else if (state_nxt == ISSUE) begin
      rd_addr_a <= ADDR_W'(gen_a);
      rd_addr_b <= ADDR_W'(gen_b);
      zeta_idx  <= gen_k;
    end else begin
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
    end
  end

  // Fixed-latency write-back delay line; shifts every cycle since the datapath never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {bf_valid, rd_addr_a, rd_addr_b};
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = pipe[PIPE_LAT-1];

endmodule
